// File: rtl/obstacle_scheduler.sv
// Obstacle sequencer for the lane-runner game: spawns one obstacle at a time in a pseudo-random lane,
// scrolls it once per frame, detects collision with the player and keeps score and speed.
module obstacle_scheduler #(
    parameter int          LANE_W        = 125,
    parameter int          SCREEN_H      = 480,
    parameter int          PLAYER_Y      = 400,
    parameter int          PLAYER_H      = 40,
    parameter int          SPAWN_GAP     = 30,
    parameter int          SPEED_INIT    = 2,
    parameter int          SPEED_MAX     = 8,
    parameter int          SPEEDUP_EVERY = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [1:0]  player_lane,
    output logic [8:0]  obs_x,
    output logic [9:0]  obs_y,
    output logic [3:0]  lane_n,
    output logic        active,
    output logic        game_over,
    output logic [15:0] score,
    output logic [3:0]  speed,
    output logic [1:0]  state
);

    localparam int GAP_W  = $clog2(SPAWN_GAP + 1);
    localparam int PASS_W = $clog2(SPEEDUP_EVERY + 1);

    localparam logic [GAP_W-1:0]  GAP_INIT     = GAP_W'(SPAWN_GAP);
    localparam logic [GAP_W-1:0]  GAP_ONE      = GAP_W'(1);
    localparam logic [PASS_W-1:0] PASS_LAST    = PASS_W'(SPEEDUP_EVERY - 1);
    localparam logic [10:0]       SCREEN_H_V   = 11'(SCREEN_H);
    localparam logic [10:0]       HIT_TOP      = 11'(PLAYER_Y);
    localparam logic [10:0]       HIT_END      = 11'(PLAYER_Y + PLAYER_H);
    localparam logic [3:0]        SPEED_INIT_V = 4'(SPEED_INIT);
    localparam logic [3:0]        SPEED_MAX_V  = 4'(SPEED_MAX);
    localparam logic [8:0]        LANE_W_V     = 9'(LANE_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FALL = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [8:0]          obs_x_q, obs_x_d;
    logic [9:0]          obs_y_q, obs_y_d;
    logic [3:0]          lane_n_q, lane_n_d;
    logic                active_q, active_d;
    logic                game_over_q, game_over_d;
    logic [15:0]         score_q, score_d;
    logic [3:0]          speed_q, speed_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [1:0]          prev_lane_q, prev_lane_d;
    logic [15:0]         lfsr_q, lfsr_d;

    logic [1:0]  cand;
    logic [1:0]  spawn_lane;
    logic [10:0] y_next;
    logic        passed;
    logic        hit;
    logic        spawn_now;

    // prev_lane always holds the lane of the obstacle currently on screen, so it doubles as the hit lane.
    assign cand       = lfsr_q[1:0];
    assign spawn_lane = (cand == prev_lane_q) ? cand + 2'd1 : cand;
    assign y_next     = {1'b0, obs_y_q} + {7'd0, speed_q};
    assign passed     = y_next >= SCREEN_H_V;
    assign hit        = (y_next >= HIT_TOP) && (y_next < HIT_END) && (player_lane == prev_lane_q);
    assign spawn_now  = frame_tick && (gap_q <= GAP_ONE);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: every flop uses <= so all registers update from the same pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_WAIT;
            S_WAIT:  if (spawn_now) state_d = S_FALL;
            S_FALL: begin
                if (frame_tick) begin
                    if (passed)   state_d = S_WAIT;
                    else if (hit) state_d = S_OVER;
                end
            end
            S_OVER:  if (start) state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            obs_x_q     <= '0;
            obs_y_q     <= '0;
            lane_n_q    <= 4'b1111;
            active_q    <= 1'b0;
            game_over_q <= 1'b0;
            score_q     <= '0;
            speed_q     <= SPEED_INIT_V;
            gap_q       <= '0;
            pass_cnt_q  <= '0;
            prev_lane_q <= '0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            obs_x_q     <= obs_x_d;
            obs_y_q     <= obs_y_d;
            lane_n_q    <= lane_n_d;
            active_q    <= active_d;
            game_over_q <= game_over_d;
            score_q     <= score_d;
            speed_q     <= speed_d;
            gap_q       <= gap_d;
            pass_cnt_q  <= pass_cnt_d;
            prev_lane_q <= prev_lane_d;
            lfsr_q      <= lfsr_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments keep this block free of inferred latches.
        obs_x_d     = obs_x_q;
        obs_y_d     = obs_y_q;
        lane_n_d    = lane_n_q;
        active_d    = active_q;
        game_over_d = game_over_q;
        score_d     = score_q;
        speed_d     = speed_q;
        gap_d       = gap_q;
        pass_cnt_d  = pass_cnt_q;
        prev_lane_d = prev_lane_q;
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    gap_d       = GAP_INIT;
                    score_d     = '0;
                    speed_d     = SPEED_INIT_V;
                    pass_cnt_d  = '0;
                    game_over_d = 1'b0;
                    lane_n_d    = 4'b1111;
                    active_d    = 1'b0;
                end
            end
            S_WAIT: begin
                if (spawn_now) begin
                    gap_d       = '0;
                    prev_lane_d = spawn_lane;
                    obs_x_d     = LANE_W_V * {7'd0, spawn_lane};
                    obs_y_d     = '0;
                    lane_n_d    = ~(4'b0001 << spawn_lane);
                    active_d    = 1'b1;
                end else if (frame_tick) begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            S_FALL: begin
                if (frame_tick) begin
                    if (passed) begin
                        active_d = 1'b0;
                        lane_n_d = 4'b1111;
                        obs_y_d  = '0;
                        gap_d    = GAP_INIT;
                        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                        if (pass_cnt_q == PASS_LAST) begin
                            pass_cnt_d = '0;
                            if (speed_q < SPEED_MAX_V) speed_d = speed_q + 4'd1;
                        end else begin
                            pass_cnt_d = pass_cnt_q + 1'b1;
                        end
                    end else begin
                        obs_y_d = y_next[9:0];
                        if (hit) game_over_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state     = state_q;
        obs_x     = obs_x_q;
        obs_y     = obs_y_q;
        lane_n    = lane_n_q;
        active    = active_q;
        game_over = game_over_q;
        score     = score_q;
        speed     = speed_q;
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomised bench for obstacle_scheduler: a frame-level game model predicts every output each cycle,
// with directed spawn/pass/collision/reset scenarios pinned by literal expectations.
module tb_obstacle_scheduler;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  player_lane = 2'd0;
    logic [8:0]  obs_x;
    logic [9:0]  obs_y;
    logic [3:0]  lane_n;
    logic        active;
    logic        game_over;
    logic [15:0] score;
    logic [3:0]  speed;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    obstacle_scheduler dut (
        .ck          (ck),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .start       (start),
        .player_lane (player_lane),
        .obs_x       (obs_x),
        .obs_y       (obs_y),
        .lane_n      (lane_n),
        .active      (active),
        .game_over   (game_over),
        .score       (score),
        .speed       (speed),
        .state       (state)
    );

    always #5 ck = ~ck;

    // Game model: phase 0 idle, 1 waiting, 2 falling, 3 game over.
    int          m_state, m_x, m_y, m_score, m_gap, m_lane;
    logic [3:0]  m_lane_n;
    bit          m_active, m_go;
    logic [15:0] m_lfsr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_speed();
        int s;
        s = 2 + m_score / 8;
        return (s > 8) ? 8 : s;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] r);
        return {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
    endfunction

    function automatic int lane_of(input logic [3:0] ln);
        for (int i = 0; i < 4; i++) if (!ln[i]) return i;
        return -1;
    endfunction

    function automatic logic [1:0] dodge();
        return 2'((m_lane + 1 + int'($urandom_range(0, 2))) % 4);
    endfunction

    task automatic model_reset();
        m_state = 0; m_x = 0; m_y = 0; m_score = 0; m_gap = 0; m_lane = 0;
        m_lane_n = 4'hF; m_active = 0; m_go = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_edge(input bit tick, input bit st, input logic [1:0] pl);
        logic [15:0] r;
        int cand, yn;
        r = m_lfsr;
        m_lfsr = lfsr_step(r);
        case (m_state)
            0, 3: if (st) begin
                m_lane_n = 4'hF; m_active = 0;
                m_state = 1; m_gap = 30; m_score = 0; m_go = 0;
            end
            1: if (tick) begin
                if (m_gap <= 1) begin
                    cand = int'(r[1:0]);
                    m_lane = (cand == m_lane) ? (cand + 1) % 4 : cand;
                    m_x = 125 * m_lane;
                    m_y = 0;
                    m_lane_n = 4'hF & ~(4'b0001 << m_lane);
                    m_active = 1;
                    m_state = 2;
                    m_gap = 0;
                end else begin
                    m_gap--;
                end
            end
            2: if (tick) begin
                yn = m_y + m_speed();
                if (yn >= 480) begin
                    m_active = 0; m_lane_n = 4'hF; m_y = 0;
                    if (m_score < 65535) m_score++;
                    m_gap = 30; m_state = 1;
                end else begin
                    m_y = yn;
                    if (yn >= 400 && yn < 440 && int'(pl) == m_lane) begin
                        m_state = 3; m_go = 1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit tick, input bit st, input logic [1:0] pl);
        frame_tick = tick; start = st; player_lane = pl;
        @(posedge ck);
        model_edge(tick, st, pl);
        @(negedge ck);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_state",  64'(state),     64'd0);
        check("rst_lane_n", 64'(lane_n),    64'hF);
        check("rst_score",  64'(score),     64'd0);
        check("rst_speed",  64'(speed),     64'd2);
        check("rst_active", 64'(active),    64'd0);
        check("rst_obs_y",  64'(obs_y),     64'd0);
        check("rst_go",     64'(game_over), 64'd0);
        model_reset();
        @(posedge ck); @(posedge ck); @(negedge ck);
        rst = 1'b0;
    endtask

    int  last_spawn  = 0;
    bit  prev_active = 1'b0;

    always @(negedge ck) begin
        if (rst) begin
            last_spawn  <= 0;
            prev_active <= 1'b0;
        end else if (cmp_en) begin
            check("outputs",
                  64'({state, obs_x, obs_y, lane_n, active, game_over, score, speed}),
                  64'({2'(m_state), 9'(m_x), 10'(m_y), m_lane_n, m_active, m_go,
                       16'(m_score), 4'(m_speed())}));
            if (active && !prev_active) begin
                check("no_repeat_lane", 64'(lane_of(lane_n) == last_spawn), 64'd0);
                last_spawn <= lane_of(lane_n);
            end
            prev_active <= active;
        end
    end

    initial begin
        logic [1:0] pl;
        int cyc;
        bit seen8, seen48;
        @(negedge ck);
        do_reset();
        cmp_en = 1'b1;

        // Start and tick together: no decrement, so spawn lands exactly on the 30th later tick.
        step(1, 1, 2'd0);
        check("start_wait", 64'(state), 64'd1);
        repeat (29) step(1, 0, 2'd0);
        check("still_wait_29", 64'(state), 64'd1);
        step(1, 0, 2'd0);
        check("spawn_state",  64'(state),  64'd2);
        check("spawn_active", 64'(active), 64'd1);
        check("spawn_y",      64'(obs_y),  64'd0);
        check("spawn_onehot", 64'($countones(~lane_n)), 64'd1);
        check("spawn_x",      64'(obs_x),  64'(125 * lane_of(lane_n)));

        // Dodge to a pass at speed 2.
        pl = 2'((m_lane + 1) % 4);
        repeat (239) step(1, 0, pl);
        check("pass_y478", 64'(obs_y), 64'd478);
        step(1, 0, pl);
        check("pass_active", 64'(active), 64'd0);
        check("pass_lane_n", 64'(lane_n), 64'hF);
        check("pass_score",  64'(score),  64'd1);
        check("pass_state",  64'(state),  64'd1);

        // Collision: sit in the spawned lane.
        repeat (30) step(1, 0, 2'd0);
        pl = 2'(m_lane);
        repeat (199) step(1, 0, pl);
        check("pre_hit_y", 64'(obs_y), 64'd398);
        step(1, 0, pl);
        check("hit_state", 64'(state),     64'd3);
        check("hit_go",    64'(game_over), 64'd1);
        check("hit_y",     64'(obs_y),     64'd400);
        repeat (5) step(1, 0, pl + 2'd1);
        check("frozen_y",     64'(obs_y), 64'd400);
        check("frozen_score", 64'(score), 64'd1);
        step(0, 1, 2'd0);
        check("restart_state",  64'(state),  64'd1);
        check("restart_score",  64'(score),  64'd0);
        check("restart_lane_n", 64'(lane_n), 64'hF);
        check("restart_active", 64'(active), 64'd0);

        // Speed ramp over 70 dodged passes with random frame spacing.
        cyc = 0; seen8 = 0; seen48 = 0;
        while (m_score < 70 && cyc < 40000) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 30) == 0), dodge());
            cyc++;
            if (m_score == 8 && !seen8) begin
                check("speed_after_8", 64'(speed), 64'd3);
                seen8 = 1;
            end
            if (m_score == 48 && !seen48) begin
                check("speed_after_48", 64'(speed), 64'd8);
                seen48 = 1;
            end
        end
        check("ramp_score", 64'(score), 64'd70);
        check("ramp_speed", 64'(speed), 64'd8);

        // Asynchronous reset in the middle of a fall.
        cyc = 0;
        while (!(m_state == 2 && m_y >= 100) && cyc < 2000) begin
            step(1, 0, dodge());
            cyc++;
        end
        check("mid_fall", 64'(state), 64'd2);
        do_reset();

        // Free play: random player lane, ticks and starts, collisions allowed.
        repeat (6000) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0),
                           2'($urandom_range(0, 3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
